// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB-Lite definitions for the FIR subsystem bus master.
//   htrans_t   : AHB transfer type encoding
//   HSIZE_*    : single-bit transfer size encoding (byte / halfword)
//   slot_t     : one pipeline slot (address or data phase) of the master
// The slot widths follow AHB_ADDR_W / AHB_DATA_W. Any module that stores
// slot_t must be built with matching address/data widths.
package ahb_pkg;

  localparam int AHB_ADDR_W = 4;
  localparam int AHB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic HSIZE_BYTE = 1'b0;
  localparam logic HSIZE_HALF = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [AHB_ADDR_W-1:0] addr;
    logic                  size;
    logic [AHB_DATA_W-1:0] wdata;
  } slot_t;

endpackage

// File: rtl/ahb_lite_master.sv
// ahb_lite_master
// Single-master AHB-Lite initiator. Commands from a valid/ready port are
// issued as pipelined NONSEQ transfers; each address phase overlaps the
// previous transfer's data phase. One in-order response per command.
//
// Ports
//   clk, n_rst          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (accept when both high at posedge)
//   cmd_write/addr/size/wdata : command fields
//   rsp_valid           : one-cycle pulse per completed or aborted command
//   rsp_rdata, rsp_err  : read data (0 for writes/errors), error flag
//   busy                : any address/data phase or abort outstanding
//   hsel/haddr/hsize/htrans/hwrite/hwdata : registered AHB-Lite master outputs
//   hrdata/hready/hresp : AHB-Lite slave response
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = AHB_ADDR_W,
  parameter int DATA_W = AHB_DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic              hsize,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  // Address slot: its fields keep their last values when it empties, so
  // haddr/hsize/hwrite hold while the bus is idle.
  slot_t             a_reg;
  // Set when the address-slot command was killed by an error response; it
  // still owes the consumer an error response but never reaches the bus.
  logic              a_aborted_reg;
  logic              d_valid_reg;
  logic              d_write_reg;
  logic [DATA_W-1:0] hwdata_reg;
  logic              abort_reg;

  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;

  logic accept;
  logic abort_start;
  logic d_retire;
  logic a_advance;
  logic aborted_rsp;

  assign cmd_ready   = (!a_reg.valid | hready) & !abort_reg;
  assign accept      = cmd_valid & cmd_ready;
  // First cycle of the two-cycle error response seen on the data phase.
  assign abort_start = hresp & !hready & d_valid_reg & !abort_reg;
  assign d_retire    = hready & d_valid_reg;
  assign a_advance   = hready & a_reg.valid;
  // The aborted command answers only after the erroring data phase has
  // retired, which keeps responses in command order.
  assign aborted_rsp = abort_reg & a_aborted_reg & !d_valid_reg;

  // Address / data slot pipeline
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_reg         <= '0;
      a_aborted_reg <= 1'b0;
      d_valid_reg   <= 1'b0;
      d_write_reg   <= 1'b0;
      hwdata_reg    <= '0;
      abort_reg     <= 1'b0;
    end else begin
      if (abort_start) begin
        // hready is low here, so a command can only be accepted at this
        // edge if the address slot was empty; either way the command is
        // parked as aborted and the bus goes IDLE next cycle.
        a_reg.valid   <= 1'b0;
        a_aborted_reg <= a_reg.valid | accept;
        abort_reg     <= 1'b1;
      end else if (accept) begin
        a_reg <= '{valid: 1'b1, write: cmd_write, addr: cmd_addr,
                   size: cmd_size, wdata: cmd_wdata};
      end else if (a_advance) begin
        a_reg.valid <= 1'b0;
      end

      if (a_advance) begin
        d_valid_reg <= 1'b1;
        d_write_reg <= a_reg.write;
        if (a_reg.write) begin
          hwdata_reg <= a_reg.wdata;
        end
      end else if (d_retire) begin
        d_valid_reg <= 1'b0;
      end

      if (abort_reg) begin
        if (d_retire && !a_aborted_reg) begin
          abort_reg <= 1'b0;
        end
        if (aborted_rsp) begin
          abort_reg     <= 1'b0;
          a_aborted_reg <= 1'b0;
        end
      end
    end
  end

  // Response register stage
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else if (d_retire) begin
      rsp_valid_reg <= 1'b1;
      rsp_err_reg   <= hresp | abort_reg;
      rsp_rdata_reg <= (!d_write_reg && !hresp && !abort_reg) ? hrdata : '0;
    end else if (aborted_rsp) begin
      rsp_valid_reg <= 1'b1;
      rsp_err_reg   <= 1'b1;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end
  end

  assign hsel      = a_reg.valid;
  assign htrans    = a_reg.valid ? NONSEQ : IDLE;
  assign haddr     = a_reg.addr;
  assign hsize     = a_reg.size;
  assign hwrite    = a_reg.write;
  assign hwdata    = hwdata_reg;
  assign busy      = a_reg.valid | d_valid_reg | abort_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule
